// File: rtl/ssr_multibin_compare_if.sv
`default_nettype none
// ============================================================================
// Module   : ssr_multibin_compare_if
// Brief    : Control/result bundle between the sequencer side and the
//            multi-bin single-shot-readout comparator.
// Revision : 1.0 - initial release
// ============================================================================
interface ssr_multibin_compare_if #(
   parameter int CNT_W    = 25,
   parameter int NUM_BINS = 2
);
   localparam int IDX_W = $clog2(NUM_BINS);

   // Level inputs toward the comparator (edge-detected inside)
   logic             ssr;
   logic             swap;
   logic             photon;
   logic             readout;
   logic             flip_clr;
   logic [CNT_W-1:0] margin;

   // Registered results and status from the comparator
   logic             flip;
   logic [IDX_W-1:0] max_idx;
   logic             res_valid;
   logic             busy;
   logic [IDX_W-1:0] cur_bin;
   logic             sat;
   logic             lost;

   // Sequencer / stimulus side
   modport master (
      output ssr, swap, photon, readout, flip_clr, margin,
      input  flip, max_idx, res_valid, busy, cur_bin, sat, lost
   );

   // Comparator side
   modport slave (
      input  ssr, swap, photon, readout, flip_clr, margin,
      output flip, max_idx, res_valid, busy, cur_bin, sat, lost
   );
endinterface
`default_nettype wire

// File: rtl/ssr_multibin_compare.sv
`default_nettype none
// ============================================================================
// Module   : ssr_multibin_compare
// Brief    : Single-shot-readout drift compensator. Photon edges count into
//            one of NUM_BINS saturating counters chosen by a rotating
//            pointer; a readout edge scans all bins one per cycle and
//            reports the largest bin and a bin0-vs-bin1 margin decision.
// Revision : 1.0 - initial release
// ============================================================================
module ssr_multibin_compare #(
   parameter int CNT_W    = 25,
   parameter int NUM_BINS = 2
) (
   input wire                     clk,
   input wire                     rst_n,
   ssr_multibin_compare_if.slave  bus
);

   localparam int               IDX_W      = $clog2(NUM_BINS);
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_BINS - 1);
   localparam logic [CNT_W-1:0] c_cnt_max  = '1;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_SCAN  = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_done;

   logic             r_ssr_q;
   logic             r_swap_q;
   logic             r_photon_q;
   logic             r_readout_q;
   logic             r_flip_clr_q;

   logic             w_ssr_e;
   logic             w_swap_e;
   logic             w_photon_e;
   logic             w_readout_e;
   logic             w_flip_clr_e;

   logic             w_in_scan;
   logic             w_photon_acc;
   logic             w_photon_lost;
   logic             w_swap_ok;
   logic             w_start;

   logic [CNT_W-1:0] r_bin [NUM_BINS];
   logic [NUM_BINS-1:0] w_sel;
   logic [NUM_BINS-1:0] w_full;
   logic             w_sat_hit;

   logic [IDX_W-1:0] r_ptr;
   logic             r_sat;
   logic             r_lost;

   logic [IDX_W-1:0] r_scan_idx;
   logic [CNT_W-1:0] r_max_val;
   logic [IDX_W-1:0] r_max_run_idx;
   logic [CNT_W-1:0] r_s_bin0;
   logic [CNT_W-1:0] r_s_bin1;
   logic [CNT_W-1:0] r_s_margin;

   logic [CNT_W-1:0] w_visit_val;
   logic             w_take;
   logic [CNT_W-1:0] w_cand_val;
   logic [IDX_W-1:0] w_cand_idx;
   logic [CNT_W:0]   w_rhs;
   logic             w_flip_new;

   logic             r_flip;
   logic [IDX_W-1:0] r_max_idx;
   logic             r_res_valid;

   // ------------------------------------------------------------------------
   // Edge detection: one event per low-to-high transition of each level
   // ------------------------------------------------------------------------
   // Delay each level input by one cycle for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ssr_q      <= 1'b0;
         r_swap_q     <= 1'b0;
         r_photon_q   <= 1'b0;
         r_readout_q  <= 1'b0;
         r_flip_clr_q <= 1'b0;
      end else begin
         r_ssr_q      <= bus.ssr;
         r_swap_q     <= bus.swap;
         r_photon_q   <= bus.photon;
         r_readout_q  <= bus.readout;
         r_flip_clr_q <= bus.flip_clr;
      end
   end

   assign w_ssr_e      = bus.ssr      & ~r_ssr_q;
   assign w_swap_e     = bus.swap     & ~r_swap_q;
   assign w_photon_e   = bus.photon   & ~r_photon_q;
   assign w_readout_e  = bus.readout  & ~r_readout_q;
   assign w_flip_clr_e = bus.flip_clr & ~r_flip_clr_q;

   // ssr outranks everything: a coincident photon/swap/readout edge is lost
   assign w_in_scan     = (r_state == ST_SCAN);
   assign w_photon_acc  = w_photon_e  & ~w_ssr_e & ~w_in_scan;
   assign w_photon_lost = w_photon_e  & ~w_ssr_e &  w_in_scan;
   assign w_swap_ok     = w_swap_e    & ~w_ssr_e;
   assign w_start       = w_readout_e & ~w_ssr_e & ~w_in_scan;

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state; w_done marks the last scan cycle that commits a result
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            if (w_start) begin
               w_state_nxt = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (w_ssr_e) begin
               w_state_nxt = ST_ACCUM;
            end else if (r_scan_idx == c_last_idx) begin
               w_state_nxt = ST_ACCUM;
               w_done      = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_ACCUM;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Bin counters
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
      assign w_sel[gi]  = (r_ptr == IDX_W'(gi));
      assign w_full[gi] = (r_bin[gi] == c_cnt_max);
   end

   // A photon into a full bin is blocked and flagged instead of wrapping
   assign w_sat_hit = w_photon_acc & |(w_sel & w_full);

   // Saturating counters, frozen during SCAN because w_photon_acc is low there
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BINS; i++) begin
            r_bin[i] <= '0;
         end
      end else if (w_ssr_e) begin
         for (int i = 0; i < NUM_BINS; i++) begin
            r_bin[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BINS; i++) begin
            if (w_photon_acc && w_sel[i] && !w_full[i]) begin
               r_bin[i] <= r_bin[i] + 1'b1;
            end
         end
      end
   end

   // Rotating pointer and sticky status flags; the photon of a coincident
   // swap uses the pointer value from before this edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr  <= '0;
         r_sat  <= 1'b0;
         r_lost <= 1'b0;
      end else if (w_ssr_e) begin
         r_ptr  <= '0;
         r_sat  <= 1'b0;
         r_lost <= 1'b0;
      end else begin
         if (w_swap_ok) begin
            r_ptr <= (r_ptr == c_last_idx) ? '0 : r_ptr + 1'b1;
         end
         if (w_sat_hit) begin
            r_sat <= 1'b1;
         end
         if (w_photon_lost) begin
            r_lost <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Sequential scan: one bin per cycle, strict compare keeps lowest index
   // ------------------------------------------------------------------------
   assign w_visit_val = r_bin[r_scan_idx];
   assign w_take      = (r_scan_idx == '0) || (w_visit_val > r_max_val);
   assign w_cand_val  = w_take ? w_visit_val : r_max_val;
   assign w_cand_idx  = w_take ? r_scan_idx  : r_max_run_idx;

   // Extra MSB keeps bin1 + margin from wrapping
   assign w_rhs      = {1'b0, r_s_bin1} + {1'b0, r_s_margin};
   assign w_flip_new = ({1'b0, r_s_bin0} > w_rhs);

   // Snapshot flip operands at the readout edge, then walk the running max
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_idx    <= '0;
         r_max_val     <= '0;
         r_max_run_idx <= '0;
         r_s_bin0      <= '0;
         r_s_bin1      <= '0;
         r_s_margin    <= '0;
      end else if (w_start) begin
         r_scan_idx <= '0;
         r_s_bin0   <= r_bin[0];
         r_s_bin1   <= r_bin[1];
         r_s_margin <= bus.margin;
      end else if (w_in_scan) begin
         r_scan_idx    <= r_scan_idx + 1'b1;
         r_max_val     <= w_cand_val;
         r_max_run_idx <= w_cand_idx;
      end
   end

   // ------------------------------------------------------------------------
   // Result registers
   // ------------------------------------------------------------------------
   // Commit results at scan end; a flip_clr edge in the commit cycle or in
   // the res_valid cycle does not erase the fresh result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flip      <= 1'b0;
         r_max_idx   <= '0;
         r_res_valid <= 1'b0;
      end else begin
         r_res_valid <= w_done;
         if (w_done) begin
            r_flip    <= w_flip_new;
            r_max_idx <= w_cand_idx;
         end else if (w_flip_clr_e && !r_res_valid) begin
            r_flip <= 1'b0;
         end
      end
   end

   assign bus.flip      = r_flip;
   assign bus.max_idx   = r_max_idx;
   assign bus.res_valid = r_res_valid;
   assign bus.busy      = (r_state == ST_SCAN);
   assign bus.cur_bin   = r_ptr;
   assign bus.sat       = r_sat;
   assign bus.lost      = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_ssr_multibin_compare.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssr_multibin_compare
// Brief    : Self-checking bench; three comparator instances (2 bins wide
//            counters, 4 bins, 2 bins with 3-bit counters) and a
//            scoreboard of expected readout results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssr_multibin_compare;

   typedef struct packed {
      logic       f;
      logic [1:0] idx;
   } res_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   ssr_multibin_compare_if #(.CNT_W(25), .NUM_BINS(2)) ia ();
   ssr_multibin_compare_if #(.CNT_W(25), .NUM_BINS(4)) ib ();
   ssr_multibin_compare_if #(.CNT_W(3),  .NUM_BINS(2)) ic ();

   ssr_multibin_compare #(.CNT_W(25), .NUM_BINS(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   ssr_multibin_compare #(.CNT_W(25), .NUM_BINS(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
   ssr_multibin_compare #(.CNT_W(3),  .NUM_BINS(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

   // level inputs per instance: bit 0 ssr, 1 swap, 2 photon, 3 readout, 4 flip_clr
   logic [4:0]  lv [3];
   logic [24:0] mg [3];

   assign ia.ssr = lv[0][0]; assign ia.swap = lv[0][1]; assign ia.photon = lv[0][2];
   assign ia.readout = lv[0][3]; assign ia.flip_clr = lv[0][4]; assign ia.margin = mg[0];
   assign ib.ssr = lv[1][0]; assign ib.swap = lv[1][1]; assign ib.photon = lv[1][2];
   assign ib.readout = lv[1][3]; assign ib.flip_clr = lv[1][4]; assign ib.margin = mg[1];
   assign ic.ssr = lv[2][0]; assign ic.swap = lv[2][1]; assign ic.photon = lv[2][2];
   assign ic.readout = lv[2][3]; assign ic.flip_clr = lv[2][4]; assign ic.margin = mg[2][2:0];

   // reference model
   longint unsigned mb [3][4];
   int              mp [3];
   int              nb [3]   = '{2, 4, 2};
   longint unsigned cmax [3] = '{64'h1FF_FFFF, 64'h1FF_FFFF, 64'd7};

   res_t sb0[$];
   res_t sb1[$];
   res_t sb2[$];
   res_t ea, eb, ec;

   function automatic res_t model_res(input int d, input longint unsigned m);
      res_t r;
      int   best;
      best  = 0;
      r.f   = (mb[d][0] > mb[d][1] + m);
      for (int j = 1; j < nb[d]; j++) begin
         if (mb[d][j] > mb[d][best]) best = j;
      end
      r.idx = 2'(best);
      return r;
   endfunction

   task automatic model_clear(input int d);
      for (int j = 0; j < 4; j++) mb[d][j] = 0;
      mp[d] = 0;
   endtask

   task automatic push_exp(input int d, input res_t e);
      case (d)
         0: sb0.push_back(e);
         1: sb1.push_back(e);
         default: sb2.push_back(e);
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one level pulse (high one cycle, low one cycle) plus model update
   task automatic ev(input int d, input int code);
      case (code)
         0: model_clear(d);
         1: mp[d] = (mp[d] + 1) % nb[d];
         2: if (mb[d][mp[d]] < cmax[d]) mb[d][mp[d]]++;
         default: ;
      endcase
      lv[d][code] = 1'b1;
      step();
      lv[d][code] = 1'b0;
      step();
   endtask

   task automatic do_readout(input int d, input longint unsigned m);
      mg[d] = 25'(m);
      push_exp(d, model_res(d, m));
      ev(d, 3);
      repeat (nb[d] + 2) step();
   endtask

   // ------------------------------------------------------------------------
   // Scoreboard monitors
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      if (rst_n && ia.res_valid) begin
         checks++;
         if (sb0.size() == 0) begin
            failures++;
            $display("FAIL sb_a_unexpected res_valid got=1 want=0");
         end else begin
            ea = sb0.pop_front();
            if ({ia.flip, 1'b0, ia.max_idx} !== ea) begin
               failures++;
               $display("FAIL sb_a_result got flip=%0b idx=%0d want flip=%0b idx=%0d",
                        ia.flip, ia.max_idx, ea.f, ea.idx);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ib.res_valid) begin
         checks++;
         if (sb1.size() == 0) begin
            failures++;
            $display("FAIL sb_b_unexpected res_valid got=1 want=0");
         end else begin
            eb = sb1.pop_front();
            if ({ib.flip, ib.max_idx} !== eb) begin
               failures++;
               $display("FAIL sb_b_result got flip=%0b idx=%0d want flip=%0b idx=%0d",
                        ib.flip, ib.max_idx, eb.f, eb.idx);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ic.res_valid) begin
         checks++;
         if (sb2.size() == 0) begin
            failures++;
            $display("FAIL sb_c_unexpected res_valid got=1 want=0");
         end else begin
            ec = sb2.pop_front();
            if ({ic.flip, 1'b0, ic.max_idx} !== ec) begin
               failures++;
               $display("FAIL sb_c_result got flip=%0b idx=%0d want flip=%0b idx=%0d",
                        ic.flip, ic.max_idx, ec.f, ec.idx);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Scenario tasks
   // ------------------------------------------------------------------------
   task automatic test_reset();
      checks++;
      if ({ia.flip, ia.max_idx, ia.res_valid, ia.busy, ia.cur_bin, ia.sat, ia.lost} !== '0) begin
         failures++;
         $display("FAIL reset_a got=%b want=0",
                  {ia.flip, ia.max_idx, ia.res_valid, ia.busy, ia.cur_bin, ia.sat, ia.lost});
      end
      checks++;
      if ({ib.flip, ib.max_idx, ib.res_valid, ib.busy, ib.cur_bin, ib.sat, ib.lost} !== '0) begin
         failures++;
         $display("FAIL reset_b got=%b want=0",
                  {ib.flip, ib.max_idx, ib.res_valid, ib.busy, ib.cur_bin, ib.sat, ib.lost});
      end
      checks++;
      if ({ic.flip, ic.max_idx, ic.res_valid, ic.busy, ic.cur_bin, ic.sat, ic.lost} !== '0) begin
         failures++;
         $display("FAIL reset_c got=%b want=0",
                  {ic.flip, ic.max_idx, ic.res_valid, ic.busy, ic.cur_bin, ic.sat, ic.lost});
      end
   endtask

   // 5 in bin0, 3 in bin1, margin 1: also checks the scan latency cycle by cycle
   task automatic test_flip_margin();
      repeat (5) ev(0, 2);
      ev(0, 1);
      checks++;
      if (ia.cur_bin !== 1'b1) begin
         failures++;
         $display("FAIL swap_ptr got=%0d want=1", ia.cur_bin);
      end
      repeat (3) ev(0, 2);
      mg[0] = 25'd1;
      push_exp(0, model_res(0, 1));
      lv[0][3] = 1'b1;
      step();                                   // cycle k+1
      lv[0][3] = 1'b0;
      checks++;
      if ({ia.busy, ia.res_valid} !== 2'b10) begin
         failures++;
         $display("FAIL scan_k1 got busy/rv=%b want=10", {ia.busy, ia.res_valid});
      end
      step();                                   // cycle k+2
      checks++;
      if ({ia.busy, ia.res_valid} !== 2'b10) begin
         failures++;
         $display("FAIL scan_k2 got busy/rv=%b want=10", {ia.busy, ia.res_valid});
      end
      step();                                   // cycle k+3
      checks++;
      if ({ia.busy, ia.res_valid, ia.flip, ia.max_idx} !== 4'b0110) begin
         failures++;
         $display("FAIL scan_k3 got busy/rv/flip/idx=%b want=0110",
                  {ia.busy, ia.res_valid, ia.flip, ia.max_idx});
      end
      step();                                   // cycle k+4
      checks++;
      if (ia.res_valid !== 1'b0) begin
         failures++;
         $display("FAIL rv_pulse got=%b want=0", ia.res_valid);
      end
   endtask

   task automatic test_margin2();
      do_readout(0, 2);
      checks++;
      if (ia.flip !== 1'b0) begin
         failures++;
         $display("FAIL margin2_flip got=%b want=0", ia.flip);
      end
   endtask

   task automatic test_flip_clr();
      do_readout(0, 1);
      ev(0, 4);
      checks++;
      if (ia.flip !== 1'b0) begin
         failures++;
         $display("FAIL flip_clr got=%b want=0", ia.flip);
      end
      // clear edge lands in the res_valid cycle: the new result must stay
      mg[0] = 25'd1;
      push_exp(0, model_res(0, 1));
      lv[0][3] = 1'b1;
      step();
      lv[0][3] = 1'b0;
      step();
      step();
      lv[0][4] = 1'b1;
      step();
      lv[0][4] = 1'b0;
      checks++;
      if (ia.flip !== 1'b1) begin
         failures++;
         $display("FAIL flip_clr_collide got=%b want=1", ia.flip);
      end
      step();
      ev(0, 4);
      checks++;
      if (ia.flip !== 1'b0) begin
         failures++;
         $display("FAIL flip_clr_after got=%b want=0", ia.flip);
      end
   endtask

   // photon edge inside SCAN is dropped; model deliberately left unchanged
   task automatic test_lost();
      mg[0] = 25'd1;
      push_exp(0, model_res(0, 1));
      lv[0][3] = 1'b1;
      step();
      lv[0][3] = 1'b0;
      lv[0][2] = 1'b1;
      step();
      lv[0][2] = 1'b0;
      repeat (3) step();
      checks++;
      if (ia.lost !== 1'b1) begin
         failures++;
         $display("FAIL lost_flag got=%b want=1", ia.lost);
      end
      do_readout(0, 1);
   endtask

   task automatic test_ssr_abort();
      lv[0][3] = 1'b1;
      step();
      lv[0][3] = 1'b0;
      checks++;
      if (ia.busy !== 1'b1) begin
         failures++;
         $display("FAIL abort_busy_pre got=%b want=1", ia.busy);
      end
      lv[0][0] = 1'b1;
      step();
      lv[0][0] = 1'b0;
      model_clear(0);
      checks++;
      if ({ia.busy, ia.res_valid, ia.lost, ia.cur_bin, ia.flip} !== 5'b00001) begin
         failures++;
         $display("FAIL abort_state got busy/rv/lost/cur/flip=%b want=00001",
                  {ia.busy, ia.res_valid, ia.lost, ia.cur_bin, ia.flip});
      end
      repeat (4) step();
      do_readout(0, 0);
      checks++;
      if (ia.flip !== 1'b0) begin
         failures++;
         $display("FAIL abort_bins_clear got flip=%b want=0", ia.flip);
      end
   endtask

   task automatic test_multibin();
      repeat (2) ev(1, 2);
      ev(1, 1);
      repeat (7) ev(1, 2);
      ev(1, 1);
      repeat (7) ev(1, 2);
      ev(1, 1);
      ev(1, 2);
      checks++;
      if (ib.cur_bin !== 2'd3) begin
         failures++;
         $display("FAIL mb_ptr3 got=%0d want=3", ib.cur_bin);
      end
      do_readout(1, 0);
      checks++;
      if (ib.max_idx !== 2'd1) begin
         failures++;
         $display("FAIL mb_max_idx got=%0d want=1", ib.max_idx);
      end
      ev(1, 1);
      checks++;
      if (ib.cur_bin !== 2'd0) begin
         failures++;
         $display("FAIL mb_wrap got=%0d want=0", ib.cur_bin);
      end
      repeat (2) ev(1, 1);
      checks++;
      if (ib.cur_bin !== 2'd2) begin
         failures++;
         $display("FAIL mb_ptr2 got=%0d want=2", ib.cur_bin);
      end
      repeat (2) ev(1, 1);
      checks++;
      if (ib.cur_bin !== 2'd0) begin
         failures++;
         $display("FAIL mb_four_swaps got=%0d want=0", ib.cur_bin);
      end
   endtask

   task automatic test_saturation();
      repeat (7) ev(2, 2);
      checks++;
      if (ic.sat !== 1'b0) begin
         failures++;
         $display("FAIL sat_early got=%b want=0", ic.sat);
      end
      repeat (2) ev(2, 2);
      checks++;
      if (ic.sat !== 1'b1) begin
         failures++;
         $display("FAIL sat_set got=%b want=1", ic.sat);
      end
      do_readout(2, 7);
      do_readout(2, 6);
   endtask

   task automatic test_rst_midscan();
      repeat (2) ev(0, 2);
      do_readout(0, 0);
      lv[0][3] = 1'b1;
      step();
      lv[0][3] = 1'b0;
      checks++;
      if ({ia.busy, ia.flip} !== 2'b11) begin
         failures++;
         $display("FAIL rst_pre got busy/flip=%b want=11", {ia.busy, ia.flip});
      end
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) model_clear(d);
      checks++;
      if ({ia.flip, ia.max_idx, ia.res_valid, ia.busy, ia.cur_bin, ia.sat, ia.lost} !== '0) begin
         failures++;
         $display("FAIL rst_midscan got=%b want=0",
                  {ia.flip, ia.max_idx, ia.res_valid, ia.busy, ia.cur_bin, ia.sat, ia.lost});
      end
      checks++;
      if (ic.sat !== 1'b0) begin
         failures++;
         $display("FAIL rst_sat_c got=%b want=0", ic.sat);
      end
      step();
      rst_n = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         lv[d] = '0;
         mg[d] = '0;
         model_clear(d);
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      test_reset();
      test_flip_margin();
      test_margin2();
      test_flip_clr();
      test_lost();
      test_ssr_abort();
      test_multibin();
      test_saturation();
      test_rst_midscan();

      checks++;
      if (sb0.size() + sb1.size() + sb2.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got=%0d pending want=0", sb0.size() + sb1.size() + sb2.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
